// File: rtl/if_fetch_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : if_fetch_queue_pkg                                         |
// | Purpose : Shared pipeline constants and types for the fetch stage:   |
// |           address width, instruction width, reset PC, queue depth.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package if_fetch_queue_pkg;

  localparam int unsigned IF_AW     = 32;
  localparam int unsigned ILEN      = 32;
  localparam int unsigned DEPTH_DEF = 4;
  localparam logic [IF_AW-1:0] RESET_PC = '0;

  typedef logic [ILEN-1:0] instr_t;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_queue_ring.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : if_fetch_ring                                              |
// | Purpose : DEPTH x {pc, instr} storage for the fetch queue. The PC    |
// |           half is written when a request is issued, the instruction  |
// |           half when its response returns; the head is read async.    |
// | Ports   : clk                  clock                                 |
// |           pc_we/waddr/wdata    PC write port (alloc side)            |
// |           instr_we/waddr/wdata instruction write port (fill side)    |
// |           raddr                head index                            |
// |           rd_pc, rd_instr      head entry contents                   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module if_fetch_ring
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = IF_AW
) (
  input  logic                     clk,
  input  logic                     pc_we,
  input  logic [$clog2(DEPTH)-1:0] pc_waddr,
  input  logic [AW-1:0]            pc_wdata,
  input  logic                     instr_we,
  input  logic [$clog2(DEPTH)-1:0] instr_waddr,
  input  instr_t                   instr_wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AW-1:0]            rd_pc,
  output instr_t                   rd_instr
);

  // Contents are deliberately not reset; validity lives in the pointers.
  logic [AW-1:0] pc_mem    [DEPTH];
  instr_t        instr_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (pc_we) begin
      pc_mem[pc_waddr] <= pc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (instr_we) begin
      instr_mem[instr_waddr] <= instr_wdata;
    end
  end

  assign rd_pc    = pc_mem[raddr];
  assign rd_instr = instr_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : if_fetch_queue                                             |
// | Purpose : Instruction-fetch queue between the PC register and the    |
// |           IF/ID boundary. Issues one imem read per cycle at pc_q,    |
// |           pairs in-order responses with their PCs and hands them to  |
// |           decode via valid/ready. Flush empties the queue and        |
// |           discards responses still in flight.                        |
// | Ports   : clk, rst_n (async, active-low)                             |
// |           pc_q / pc_en          PC register interface                |
// |           imem_req_*            fetch request (valid/ready)          |
// |           imem_rsp_*            in-order fetch response              |
// |           flush                 branch redirect                      |
// |           id_valid/instr/pc     head entry toward decode             |
// |           id_ready              decode accepts head                  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = IF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_q,
  output logic          pc_en,
  output logic          imem_req_valid,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_req_ready,
  input  logic          imem_rsp_valid,
  input  instr_t        imem_rsp_data,
  input  logic          flush,
  output logic          id_valid,
  output instr_t        id_instr,
  output logic [AW-1:0] id_pc,
  input  logic          id_ready
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   DEPTH_W = (PW + 1)'(DEPTH);

  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] drop_cnt;

  logic [PW-1:0] reserved;
  logic [PW-1:0] in_flight;
  logic [PW:0]   occupancy;
  logic          req_fire;
  logic          rsp_fill;
  logic          rsp_drop;
  logic          deq;
  logic [PW-1:0] flush_drop;

  // Entries issued-or-filled, plus stale responses still owed by memory;
  // together they bound what memory may return, so both count toward full.
  assign reserved  = alloc_ptr - rd_ptr;
  assign in_flight = alloc_ptr - fill_ptr;
  assign occupancy = {1'b0, reserved} + {1'b0, drop_cnt};

  // Gated by rst_n so the request is low for the whole reset window.
  assign imem_req_valid = rst_n && !flush && (occupancy < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pc_en          = req_fire;

  // Stale responses are consumed before any live entry is filled.
  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && (in_flight != '0);

  assign id_valid = (fill_ptr != rd_ptr);
  assign deq      = id_valid && id_ready && !flush;

  // Everything not yet returned at flush time, less this cycle's response
  // (whether it would have filled or been dropped), must be discarded.
  assign flush_drop = in_flight - (rsp_fill ? PTR_ONE : '0)
                    + drop_cnt  - (rsp_drop ? PTR_ONE : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= flush_drop;
    end else begin
      if (req_fire) begin
        alloc_ptr <= alloc_ptr + PTR_ONE;
      end
      if (rsp_fill) begin
        fill_ptr <= fill_ptr + PTR_ONE;
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - PTR_ONE;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  if_fetch_ring #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ring (
    .clk         (clk),
    .pc_we       (req_fire),
    .pc_waddr    (alloc_ptr[IW-1:0]),
    .pc_wdata    (pc_q),
    .instr_we    (rsp_fill),
    .instr_waddr (fill_ptr[IW-1:0]),
    .instr_wdata (imem_rsp_data),
    .raddr       (rd_ptr[IW-1:0]),
    .rd_pc       (id_pc),
    .rd_instr    (id_instr)
  );

`ifndef SYNTHESIS
  // A response with nothing outstanding is a memory protocol violation.
  a_rsp_unexpected : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (drop_cnt == '0) && (in_flight == '0))
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_if_fetch_queue                                          |
// | Purpose : Directed self-checking bench for if_fetch_queue. Models    |
// |           the PC register and an in-order fixed-latency memory, and  |
// |           scoreboards every instruction handed to decode.            |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_if_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc_q;
  logic          pc_en;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          flush;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [AW-1:0] id_pc;
  logic          id_ready;

  if_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_q           (pc_q),
    .pc_en          (pc_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  int          cyc;
  int          lat;
  logic [31:0] tgt;
  logic [31:0] exp_pc;
  int          n_chk;
  int          n_fail;
  int          n_deq;
  int          n_acc;

  logic        s_req, s_pcen, s_idv;
  logic [31:0] s_addr, s_idpc, s_idi;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive after negedge, sample, clock, update models.
  task automatic step(input logic fl, input logic rdy, input logic idr);
    flush          = fl;
    imem_req_ready = rdy;
    id_ready       = idr;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    s_req  = imem_req_valid;
    s_pcen = pc_en;
    s_idv  = id_valid;
    s_addr = imem_req_addr;
    s_idpc = id_pc;
    s_idi  = id_instr;
    check("req_addr", {32'd0, s_addr}, {32'd0, pc_q});
    if (s_idv && idr && !fl) begin
      check("deq_pc", {32'd0, s_idpc}, {32'd0, exp_pc});
      check("deq_instr", {32'd0, s_idi}, {32'd0, mem_data(exp_pc)});
      exp_pc = exp_pc + 32'd4;
      n_deq++;
    end
    @(posedge clk);
    #1;
    if (imem_rsp_valid) void'(pend.pop_front());
    imem_rsp_valid = 1'b0;
    if (s_pcen) begin
      pend.push_back('{addr: pc_q, due: cyc + lat});
      pc_q = pc_q + 32'd4;
      n_acc++;
    end
    if (fl) begin
      pc_q   = tgt;
      exp_pc = tgt;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    flush          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_ready       = 1'b0;
    pend.delete();
    pc_q   = '0;
    exp_pc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_acc = 0;
    n_deq = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; lat = 1; tgt = '0;
    rst_n = 1'b0;
    pc_q  = '0;
    flush = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; id_ready = 1'b1;
    #2;
    check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("rst_pc_en", {63'd0, pc_en}, 64'd0);
    do_reset();

    // ---- Streaming, latency 1 ----
    lat = 1;
    step(0, 1, 1); check("strm_c0_pcen", {63'd0, s_pcen}, 64'd1);
    check("strm_c0_idv", {63'd0, s_idv}, 64'd0);
    step(0, 1, 1); check("strm_c1_idv", {63'd0, s_idv}, 64'd0);
    step(0, 1, 1); check("strm_c2_idv", {63'd0, s_idv}, 64'd1);
    check("strm_c2_pc", {32'd0, s_idpc}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1);
      check("strm_tput", {63'd0, s_idv}, 64'd1);
    end
    check("strm_ndeq", 64'(n_deq), 64'd9);

    // ---- Backpressure ----
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    check("bp_accepted", 64'(n_acc), 64'(DEPTH));
    check("bp_full_req", {63'd0, s_req}, 64'd0);
    check("bp_full_pcen", {63'd0, s_pcen}, 64'd0);
    step(0, 1, 1); check("bp_d1_pcen", {63'd0, s_pcen}, 64'd0);
    step(0, 1, 1); check("bp_d2_pcen", {63'd0, s_pcen}, 64'd1);
    check("bp_d2_addr", {32'd0, s_addr}, 64'h10);
    step(0, 1, 1);
    step(0, 1, 1);
    check("bp_drained", 64'(n_deq), 64'd4);

    // ---- Flush with three in flight, latency 4 ----
    do_reset();
    lat = 4; tgt = 32'h100;
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    step(1, 1, 1); check("fl_req_in_flush", {63'd0, s_req}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1);
      check("fl_idv_low", {63'd0, s_idv}, 64'd0);
    end
    step(0, 1, 1); check("fl_first_idv", {63'd0, s_idv}, 64'd1);
    check("fl_first_pc", {32'd0, s_idpc}, 64'h100);

    // ---- Flush coinciding with a response, latency 2 ----
    do_reset();
    lat = 2; tgt = 32'h200;
    step(0, 1, 1);
    step(0, 1, 1);
    step(1, 1, 1); check("flr_rsp_in_flush", {63'd0, imem_rsp_valid | 1'b0}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1);
      check("flr_idv_low", {63'd0, s_idv}, 64'd0);
    end
    step(0, 1, 1); check("flr_first_idv", {63'd0, s_idv}, 64'd1);
    check("flr_first_pc", {32'd0, s_idpc}, 64'h200);
    check("flr_first_instr", {32'd0, s_idi}, {32'd0, mem_data(32'h200)});

    // ---- Memory stall ----
    do_reset();
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1);
      check("stall_pcen", {63'd0, s_pcen}, 64'd0);
      check("stall_req", {63'd0, s_req}, 64'd1);
      check("stall_idv", {63'd0, s_idv}, 64'd0);
    end
    check("stall_addr", {32'd0, s_addr}, 64'd0);
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 1, 1); check("stall_resume_idv", {63'd0, s_idv}, 64'd1);
    check("stall_resume_pc", {32'd0, s_idpc}, 64'd0);

    // ---- Reset mid-stream with three entries buffered ----
    do_reset();
    lat = 1;
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    step(0, 0, 0);
    check("mrst_pre_idv", {63'd0, id_valid}, 64'd1);
    imem_req_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_idv", {63'd0, id_valid}, 64'd0);
    check("mrst_req", {63'd0, imem_req_valid}, 64'd0);
    check("mrst_pcen", {63'd0, pc_en}, 64'd0);
    do_reset();
    step(0, 1, 1);
    check("mrst_first_req", {63'd0, s_req}, 64'd1);
    check("mrst_first_pcen", {63'd0, s_pcen}, 64'd1);
    check("mrst_first_addr", {32'd0, s_addr}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
